// File: rtl/aibnd_red_shift_ctrl.sv
// Redundancy shift controller for a row of AIB IO buffer cells: holds the row in reset,
// loads thermometer-coded shift_en, then releases analog and digital reset. Option: AIBND_RED_SHIFT_STAGGER_EN.
module aibnd_red_shift_ctrl #(
    parameter int NUM_IO     = 24,
    parameter int IDX_W      = 7,
    parameter int SETTLE_CYC = 8
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              cfg_req,
    input  logic              red_en,
    input  logic [IDX_W-1:0]  red_idx,
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic              busy,
    output logic [NUM_IO-1:0] shift_en,
    output logic              anlg_rstb_out,
    output logic              dig_rstb_out
);
    localparam int                CNT_W    = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W:0]    NUM_IO_X = (IDX_W + 1)'(NUM_IO);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE_RST, S_SHIFT, S_POST, S_ANLG_REL, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                red_en_q, red_en_d;
    logic [IDX_W-1:0]    red_idx_q, red_idx_d;
    logic                cfg_ack_q, cfg_ack_d;
    logic                cfg_err_q, cfg_err_d;
    logic                busy_q, busy_d;
    logic [NUM_IO-1:0]   shift_en_q, shift_en_d;
    logic                anlg_q, anlg_d;
    logic                dig_q, dig_d;
    logic [NUM_IO-1:0]   thermo;
    logic                cnt_last;
`ifdef AIBND_RED_SHIFT_STAGGER_EN
    logic [NUM_IO-1:0]   load_mask_q, load_mask_d;
`endif

    // Target pattern: every cell at or above the failed pad shifts up by one.
    for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_thermo
        assign thermo[gi] = red_en_q & ({1'b0, red_idx_q} <= (IDX_W + 1)'(gi));
    end

    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        red_en_d   = red_en_q;
        red_idx_d  = red_idx_q;
        cfg_ack_d  = 1'b0;
        cfg_err_d  = cfg_err_q;
        shift_en_d = shift_en_q;
        anlg_d     = anlg_q;
        dig_d      = dig_q;
`ifdef AIBND_RED_SHIFT_STAGGER_EN
        load_mask_d = load_mask_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cfg_req) begin
                    red_en_d  = red_en;
                    red_idx_d = red_idx;
                    cfg_err_d = 1'b0;
                    if (red_en && ({1'b0, red_idx} >= NUM_IO_X)) begin
                        state_d   = S_DONE;
                        cfg_err_d = 1'b1;
                        cfg_ack_d = 1'b1;
                    end else begin
                        state_d = S_PRE_RST;
                        cnt_d   = '0;
                        anlg_d  = 1'b0;
                        dig_d   = 1'b0;
                    end
                end
            end
            S_PRE_RST: begin
                cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    state_d = S_SHIFT;
`ifdef AIBND_RED_SHIFT_STAGGER_EN
                    load_mask_d = {1'b1, {(NUM_IO-1){1'b0}}};
`endif
                end
            end
            S_SHIFT: begin
`ifdef AIBND_RED_SHIFT_STAGGER_EN
                // One cell per cycle, top down, to spread the mux switching current.
                shift_en_d  = (shift_en_q & ~load_mask_q) | (thermo & load_mask_q);
                load_mask_d = load_mask_q >> 1;
                if (load_mask_q[0]) state_d = S_POST;
`else
                shift_en_d = thermo;
                state_d    = S_POST;
`endif
            end
            S_POST: begin
                cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    state_d = S_ANLG_REL;
                    anlg_d  = 1'b1;
                end
            end
            S_ANLG_REL: begin
                cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    state_d   = S_DONE;
                    dig_d     = 1'b1;
                    cfg_ack_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            red_en_q   <= 1'b0;
            red_idx_q  <= '0;
            cfg_ack_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            shift_en_q <= '0;
            anlg_q     <= 1'b0;
            dig_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            red_en_q   <= red_en_d;
            red_idx_q  <= red_idx_d;
            cfg_ack_q  <= cfg_ack_d;
            cfg_err_q  <= cfg_err_d;
            busy_q     <= busy_d;
            shift_en_q <= shift_en_d;
            anlg_q     <= anlg_d;
            dig_q      <= dig_d;
        end
    end

`ifdef AIBND_RED_SHIFT_STAGGER_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) load_mask_q <= '0;
        else       load_mask_q <= load_mask_d;
    end
`endif

    assign cfg_ack       = cfg_ack_q;
    assign cfg_err       = cfg_err_q;
    assign busy          = busy_q;
    assign shift_en      = shift_en_q;
    assign anlg_rstb_out = anlg_q;
    assign dig_rstb_out  = dig_q;
endmodule
